// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: pipelined radix-4 Booth / Wallace N x N multiplier with valid/ready handshake.
// Define WALLACE_MUL_FLAGS_EN to add the registered o_zero / o_msb result flags.
module wallace_mul_pipe #(
  parameter int N = 24,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  input  logic             i_signed,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2*N-1:0]   o_product,
  output logic [TAG_W-1:0] o_tag
`ifdef WALLACE_MUL_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_msb
`endif
);
  localparam int W = 2 * N;
  localparam int D = N / 2 + 1;
  localparam int R0 = D + 1;

  function automatic int rows_at(input int n_lvl);
    int r;
    r = R0;
    for (int i = 0; i < n_lvl; i++) r = r / 3 * 2 + r % 3;
    return r;
  endfunction

  function automatic int off(input int n_lvl);
    int s;
    s = 0;
    for (int i = 0; i < n_lvl; i++) s = s + rows_at(i);
    return s;
  endfunction

  function automatic int levels();
    int l;
    l = 0;
    while (rows_at(l) > 2) l = l + 1;
    return l;
  endfunction

  function automatic logic [W-1:0] booth_row(input logic [W-1:0] m, input logic [2:0] d);
    logic [W-1:0] mag;
    mag = (d[1] ^ d[0]) ? m : (d[2] ^ d[1]) ? m << 1 : '0;
    return d[2] ? ~mag : mag;
  endfunction

  localparam int L = levels();
  localparam int M = L / 2;
  localparam int TOT = off(L) + 2;

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("wallace_mul_pipe: PIPE_DEPTH must be 1..4");
  end
  if (N % 2 != 0 || N < 8 || N > 32) begin : g_bad_width
    $error("wallace_mul_pipe: N must be even and 8..32");
  end

  logic                 en;
  logic                 v0, v1, v2, sg0;
  logic [N-1:0]         a0, b0;
  logic [TAG_W-1:0]     g0, g1, g2;
  logic [W-1:0]         aw, s2, c2, sum;
  logic [N+2:0]         bx;
  logic [R0-1:0][W-1:0] pp;
  logic [TOT-1:0][W-1:0] rows;

  assign en = !o_valid | i_ready;
  assign o_ready = en;

  if (PIPE_DEPTH == 4) begin : g_opr
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        v0 <= 1'b0;
        g0 <= '0;
        sg0 <= 1'b0;
        a0 <= '0;
        b0 <= '0;
      end else if (en) begin
        v0 <= i_valid;
        g0 <= i_tag;
        sg0 <= i_signed;
        a0 <= i_a;
        b0 <= i_b;
      end
  end else begin : g_opn
    assign {v0, g0, sg0, a0, b0} = {i_valid, i_tag, i_signed, i_a, i_b};
  end

  assign aw = {{N{sg0 & a0[N-1]}}, a0};
  assign bx = {{2{sg0 & b0[N-1]}}, b0, 1'b0};

  // Negated rows are stored inverted; the +1 of each negation sits in the last row at bit 2i.
  always_comb begin
    pp = '0;
    for (int i = 0; i < D; i++) begin
      pp[i] = booth_row(aw, bx[2*i +: 3]) << (2 * i);
      pp[D][2*i] = bx[2*i+2];
    end
  end

  assign rows[R0-1:0] = pp;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int R = rows_at(k);
    localparam int G = R / 3;
    localparam int I = off(k);
    localparam int O = off(k + 1);
    logic [R-1:0][W-1:0] cur;
    if (k == M && PIPE_DEPTH >= 3) begin : g_mid
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cur <= '0;
        else if (en) cur <= rows[I +: R];
    end else begin : g_comb
      assign cur = rows[I +: R];
    end
    for (genvar j = 0; j < G; j++) begin : g_csa
      assign rows[O+2*j] = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
      assign rows[O+2*j+1] = ((cur[3*j] & cur[3*j+1]) | (cur[3*j+2] & (cur[3*j] ^ cur[3*j+1]))) << 1;
    end
    if (R % 3 == 2) begin : g_ha
      assign rows[O+2*G] = cur[3*G] ^ cur[3*G+1];
      assign rows[O+2*G+1] = (cur[3*G] & cur[3*G+1]) << 1;
    end else if (R % 3 == 1) begin : g_pass
      assign rows[O+2*G] = cur[3*G];
    end
  end

  if (PIPE_DEPTH >= 3) begin : g_vmid
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        v1 <= 1'b0;
        g1 <= '0;
      end else if (en) begin
        v1 <= v0;
        g1 <= g0;
      end
  end else begin : g_vnomid
    assign {v1, g1} = {v0, g0};
  end

  if (PIPE_DEPTH >= 2) begin : g_cs
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        v2 <= 1'b0;
        g2 <= '0;
        s2 <= '0;
        c2 <= '0;
      end else if (en) begin
        v2 <= v1;
        g2 <= g1;
        s2 <= rows[TOT-2];
        c2 <= rows[TOT-1];
      end
  end else begin : g_csn
    assign {v2, g2, s2, c2} = {v1, g1, rows[TOT-2], rows[TOT-1]};
  end

  assign sum = s2 + c2;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_product <= '0;
      o_tag <= '0;
    end else if (en) begin
      o_valid <= v2;
      o_product <= sum;
      o_tag <= g2;
    end

`ifdef WALLACE_MUL_FLAGS_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_zero <= 1'b0;
      o_msb <= 1'b0;
    end else if (en) begin
      o_zero <= sum == '0;
      o_msb <= sum[W-1];
    end
`endif
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// tb_wallace_mul_pipe: directed vectors, per-depth streaming, backpressure, random handshake and reset checks.
module tb_wallace_mul_pipe;
  localparam int N = 24;
  localparam int W = 48;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    logic [3:0]   tag;
    logic [W-1:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic rdy = 1'b1;
  logic sgn = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0] tag = '0;
  logic ov [1:4];
  logic ordy [1:4];
  logic [W-1:0] op [1:4];
  logic [3:0] ot [1:4];
`ifdef WALLACE_MUL_FLAGS_EN
  logic oz [1:4];
  logic om [1:4];
`endif
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  for (genvar d = 1; d <= 4; d++) begin : g_dut
    wallace_mul_pipe #(.N(N), .PIPE_DEPTH(d), .TAG_W(4)) u_dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_valid(valid),
      .o_ready(ordy[d]),
      .i_a(a),
      .i_b(b),
      .i_signed(sgn),
      .i_tag(tag),
      .o_valid(ov[d]),
      .i_ready(rdy),
      .o_product(op[d]),
      .o_tag(ot[d])
`ifdef WALLACE_MUL_FLAGS_EN
      ,
      .o_zero(oz[d]),
      .o_msb(om[d])
`endif
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    logic [W-1:0] sx, sy;
    sx = {{N{s & x[N-1]}}, x};
    sy = {{N{s & y[N-1]}}, y};
    return sx * sy;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tv [14];
    logic [N-1:0] sa [16];
    logic [N-1:0] sb [16];
    logic ss [16];
    logic [51:0] exp_q [$];
    logic [51:0] e;
    int sent, got, cyc;
    logic acc;
    tv[0]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'h1, 48'hFFFFFE000001};
    tv[1]  = '{24'h800000, 24'h800000, 1'b1, 4'h2, 48'h400000000000};
    tv[2]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'h3, 48'h000000000001};
    tv[3]  = '{24'h7FFFFF, 24'h800000, 1'b1, 4'h4, 48'hC00000800000};
    tv[4]  = '{24'h000000, 24'h123456, 1'b0, 4'h5, 48'h000000000000};
    tv[5]  = '{24'h400000, 24'h000002, 1'b0, 4'h6, 48'h000000800000};
    tv[6]  = '{24'h000003, 24'hFFFFFD, 1'b1, 4'h7, 48'hFFFFFFFFFFF7};
    tv[7]  = '{24'h800000, 24'h000001, 1'b1, 4'h8, 48'hFFFFFF800000};
    tv[8]  = '{24'h7FFFFF, 24'h7FFFFF, 1'b1, 4'h9, 48'h3FFFFF000001};
    tv[9]  = '{24'hFFFFFF, 24'h000002, 1'b0, 4'hA, 48'h000001FFFFFE};
    tv[10] = '{24'h001000, 24'h001000, 1'b0, 4'hB, 48'h000001000000};
    tv[11] = '{24'h800000, 24'hFFFFFF, 1'b1, 4'hC, 48'h000000800000};
    tv[12] = '{24'hFFFFFF, 24'h000000, 1'b1, 4'hD, 48'h000000000000};
    tv[13] = '{24'h000003, 24'hFFFFFD, 1'b0, 4'hE, 48'h000002FFFFF7};

    repeat (2) @(negedge clk);
    check("rst_valid", ov[2], 0);
    check("rst_product", op[2], 0);
    check("rst_tag", ot[2], 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", ordy[2], 1);

    foreach (tv[i]) begin
      a = tv[i].a;
      b = tv[i].b;
      sgn = tv[i].s;
      tag = tv[i].tag;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      check($sformatf("vec%0d_early", i), ov[2], 0);
      tick();
      check($sformatf("vec%0d_valid", i), ov[2], 1);
      check($sformatf("vec%0d_product", i), op[2], tv[i].p);
      check($sformatf("vec%0d_tag", i), ot[2], tv[i].tag);
`ifdef WALLACE_MUL_FLAGS_EN
      check($sformatf("vec%0d_zero", i), oz[2], tv[i].p == '0);
      check($sformatf("vec%0d_msb", i), om[2], tv[i].p[W-1]);
`endif
      tick();
      check($sformatf("vec%0d_drained", i), ov[2], 0);
    end
    repeat (4) tick();

    for (int j = 0; j < 16; j++) begin
      sa[j] = 24'($urandom);
      sb[j] = 24'($urandom);
      ss[j] = 1'($urandom);
    end
    for (int c = 0; c < 21; c++) begin
      for (int d = 1; d <= 4; d++) begin
        if (c - d >= 0 && c - d < 16)
          check($sformatf("stream_d%0d_c%0d", d, c), {ov[d], ot[d], op[d]},
                {1'b1, 4'(c - d), model(sa[c-d], sb[c-d], ss[c-d])});
        else
          check($sformatf("stream_d%0d_c%0d_idle", d, c), ov[d], 0);
      end
      valid = c < 16;
      if (c < 16) begin
        a = sa[c];
        b = sb[c];
        sgn = ss[c];
        tag = 4'(c);
      end
      tick();
    end

    valid = 1'b1;
    a = 24'h000005; b = 24'h000007; sgn = 1'b0; tag = 4'h5;
    tick();
    a = 24'h000100; b = 24'h000100; sgn = 1'b0; tag = 4'h6;
    tick();
    check("bp_first", {ov[2], ot[2], op[2]}, {1'b1, 4'h5, 48'h23});
    a = 24'hFFFFFF; b = 24'h000003; sgn = 1'b1; tag = 4'h7;
    rdy = 1'b0;
    #1;
    check("bp_ready_low", ordy[2], 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold%0d", k), {ov[2], ot[2], op[2]}, {1'b1, 4'h5, 48'h23});
      check($sformatf("bp_hold%0d_ready", k), ordy[2], 0);
    end
    rdy = 1'b1;
    #1;
    check("bp_ready_release", ordy[2], 1);
    tick();
    valid = 1'b0;
    check("bp_second", {ov[2], ot[2], op[2]}, {1'b1, 4'h6, 48'h10000});
    tick();
    check("bp_third", {ov[2], ot[2], op[2]}, {1'b1, 4'h7, 48'hFFFFFFFFFFFD});
    tick();
    check("bp_empty", ov[2], 0);

    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      if (!valid && sent < 1000 && $urandom_range(0, 9) < 7) begin
        a = 24'($urandom);
        b = 24'($urandom);
        sgn = 1'($urandom);
        tag = 4'(sent);
        valid = 1'b1;
      end
      rdy = $urandom_range(0, 9) < 6;
      #1;
      acc = valid && ordy[2];
      if (acc) exp_q.push_back({tag, model(a, b, sgn)});
      if (ov[2] && rdy) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        check($sformatf("rand_%0d", got), {ot[2], op[2]}, e);
        got++;
      end
      tick();
      if (acc) begin
        valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    check("rand_count", got, 1000);
    check("rand_leftover", exp_q.size(), 0);
    rdy = 1'b1;
    valid = 1'b0;
    repeat (5) tick();

    valid = 1'b1;
    a = 24'h111111; b = 24'h000002; sgn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tag = 4'(k + 8);
      tick();
    end
    valid = 1'b0;
    check("pre_rst_out", {ov[2], ot[2], op[2]}, {1'b1, 4'h9, 48'h222222});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", ov[2], 0);
    check("rst_async_product", op[2], 0);
    check("rst_async_tag", ot[2], 0);
    check("rst_async_valid_d4", ov[4], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", ordy[2], 1);
    check("post_rst_idle", ov[2], 0);
    a = 24'h000010; b = 24'h000010; sgn = 1'b0; tag = 4'h3;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("post_rst_early", ov[2], 0);
    tick();
    check("post_rst_result", {ov[2], ot[2], op[2]}, {1'b1, 4'h3, 48'h100});
    tick();
    check("post_rst_no_stale", ov[2], 0);
    tick();
    check("post_rst_no_stale2", ov[2], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
